// File: rtl/io_control_xfer_if.sv
// Bus-side signal bundle for io_control_xfer: CPU control lines, device ready,
// and the registered select/strobe/status outputs.
interface io_control_xfer_if #(
  parameter int DATA_W = 8,
  parameter int X_BITS = 3,
  parameter int Y_BITS = 3
) ();
  logic [DATA_W-1:0]      bus;
  logic                   loadn;
  logic                   from_devn;
  logic                   to_devn;
  logic                   dev_rdy;
  logic [2**X_BITS-1:0]   sel_x;
  logic [2**Y_BITS-1:0]   sel_y;
  logic                   rdn;
  logic                   wrn;
  logic                   busy;
  logic                   err;

  modport master (
    output bus, loadn, from_devn, to_devn, dev_rdy,
    input  sel_x, sel_y, rdn, wrn, busy, err
  );

  modport slave (
    input  bus, loadn, from_devn, to_devn, dev_rdy,
    output sel_x, sel_y, rdn, wrn, busy, err
  );
endinterface

// File: rtl/io_control_xfer.sv
// I/O controller: latches a device address, drives active-low one-hot selects and
// runs a handshaked read/write transfer FSM with wait states, timeout and auto-increment.
module io_control_xfer #(
  parameter int DATA_W   = 8,
  parameter int X_BITS   = 3,
  parameter int Y_BITS   = 3,
  parameter int AUTO_INC = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rstn,
  io_control_xfer_if.slave io
);
  localparam int ADDR_W = X_BITS + Y_BITS;
  localparam int NX     = 2**X_BITS;
  localparam int NY     = 2**Y_BITS;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_loaded;
  logic                r_dir_rd;
  logic                r_rdn;
  logic                r_wrn;
  logic                r_busy;
  logic                r_err;
  logic [NX-1:0]       r_sel_x;
  logic [NY-1:0]       r_sel_y;

  logic [ADDR_W-1:0]   w_bus_addr;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic                w_timeout;
  logic                w_unused;

  function automatic logic [NX-1:0] dec_x(input logic [X_BITS-1:0] a);
    return ~({{(NX-1){1'b0}}, 1'b1} << a);
  endfunction

  function automatic logic [NY-1:0] dec_y(input logic [Y_BITS-1:0] a);
    return ~({{(NY-1){1'b0}}, 1'b1} << a);
  endfunction

  assign w_bus_addr = io.bus[ADDR_W-1:0];
  assign w_addr_inc = r_addr + ADDR_W'(AUTO_INC);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT));
  assign w_unused   = ^io.bus;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_dir_rd <= 1'b0;
      r_rdn    <= 1'b1;
      r_wrn    <= 1'b1;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_sel_x  <= '1;
      r_sel_y  <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!io.loadn) begin
            r_addr   <= w_bus_addr;
            r_err    <= 1'b0;
            r_loaded <= 1'b1;
            r_sel_x  <= dec_x(w_bus_addr[X_BITS-1:0]);
            r_sel_y  <= dec_y(w_bus_addr[X_BITS +: Y_BITS]);
          end else if (io.from_devn ^ io.to_devn) begin
            r_state  <= S_SETUP;
            r_busy   <= 1'b1;
            r_dir_rd <= ~io.from_devn;
          end else if (!io.from_devn && !io.to_devn) begin
            r_err <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          if (r_dir_rd) r_rdn <= 1'b0;
          else          r_wrn <= 1'b0;
        end
        S_STROBE: begin
          // dev_rdy wins over timeout when both land on the same edge
          if (io.dev_rdy || w_timeout) begin
            if (!io.dev_rdy) r_err <= 1'b1;
            r_state <= S_DONE;
            r_rdn   <= 1'b1;
            r_wrn   <= 1'b1;
            r_addr  <= w_addr_inc;
            if (r_loaded) begin
              r_sel_x <= dec_x(w_addr_inc[X_BITS-1:0]);
              r_sel_y <= dec_y(w_addr_inc[X_BITS +: Y_BITS]);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.sel_x = r_sel_x;
  assign io.sel_y = r_sel_y;
  assign io.rdn   = r_rdn;
  assign io.wrn   = r_wrn;
  assign io.busy  = r_busy;
  assign io.err   = r_err;
endmodule

// File: tb/tb_io_control_xfer.sv
// Self-checking bench for io_control_xfer: vector table of transfers with a scoreboard
// queue checked at each busy fall, plus hand sequences for load/reset corner cases.
module tb_io_control_xfer;
  localparam int TO = 15;

  logic clk;
  logic rstn;

  io_control_xfer_if #(.DATA_W(8), .X_BITS(3), .Y_BITS(3)) io ();

  io_control_xfer #(
    .DATA_W(8), .X_BITS(3), .Y_BITS(3), .AUTO_INC(1), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_load;
    logic [7:0]  load_val;
    logic [7:0]  ld_x;
    logic [7:0]  ld_y;
    logic        is_read;
    int unsigned rdy_delay;
    int unsigned exp_strobe;
    logic        exp_err;
    logic [7:0]  exp_x;
    logic [7:0]  exp_y;
  } vec_t;

  typedef struct {
    logic        is_read;
    int unsigned strobe;
    logic        err;
    logic [7:0]  sel_x;
    logic [7:0]  sel_y;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: counts strobe/busy cycles, compares at each busy fall
  initial begin : monitor
    logic prev_busy;
    int   n_rd, n_wr, n_busy;
    exp_t e;
    prev_busy = 1'b0; n_rd = 0; n_wr = 0; n_busy = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_busy = 1'b0; n_rd = 0; n_wr = 0; n_busy = 0;
      end else begin
        if (io.busy)  n_busy++;
        if (!io.rdn)  n_rd++;
        if (!io.wrn)  n_wr++;
        if (prev_busy && !io.busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rdn_cycles",  n_rd,   e.is_read ? e.strobe : 0);
            check("wrn_cycles",  n_wr,   e.is_read ? 0 : e.strobe);
            check("busy_cycles", n_busy, e.strobe + 2);
            check("xfer_err",    io.err, e.err);
            check("xfer_sel_x",  io.sel_x, e.sel_x);
            check("xfer_sel_y",  io.sel_y, e.sel_y);
          end
          n_rd = 0; n_wr = 0; n_busy = 0;
        end
        prev_busy = io.busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    io.bus   = v;
    io.loadn = 1'b0;
    @(negedge clk);
    io.loadn = 1'b1;
  endtask

  task automatic do_xfer(input logic rd, input int unsigned d);
    bit done;
    done = 0;
    @(negedge clk);
    io.dev_rdy = (d == 0);
    if (rd) io.from_devn = 1'b0;
    else    io.to_devn   = 1'b0;
    @(negedge clk);
    io.from_devn = 1'b1;
    io.to_devn   = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == d) io.dev_rdy = 1'b1;
      if (!io.busy) begin
        done = 1;
        break;
      end
    end
    io.dev_rdy = 1'b0;
    check("xfer_completes", done, 1);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (io.busy === lvl) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  vec_t vecs[7];

  initial begin : stim
    exp_t e;
    int   gap;
    bit   ok;

    vecs[0] = '{1'b1, 8'h34, 8'hEF, 8'hBF, 1'b0, 0,  1,  1'b0, 8'hDF, 8'hBF};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 4,  5,  1'b0, 8'hBF, 8'hBF};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 20, 16, 1'b1, 8'h7F, 8'hBF};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 0,  1,  1'b1, 8'hFE, 8'h7F};
    vecs[4] = '{1'b1, 8'h3F, 8'h7F, 8'h7F, 1'b0, 0,  1,  1'b0, 8'hFE, 8'hFE};
    vecs[5] = '{1'b1, 8'hC5, 8'hDF, 8'hFE, 1'b1, 2,  3,  1'b0, 8'hBF, 8'hFE};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 15, 16, 1'b0, 8'h7F, 8'hFE};

    rstn = 1'b0;
    io.bus = 8'h00; io.loadn = 1'b1; io.from_devn = 1'b1; io.to_devn = 1'b1;
    io.dev_rdy = 1'b0;
    #12;
    check("rst_sel_x", io.sel_x, 8'hFF);
    check("rst_sel_y", io.sel_y, 8'hFF);
    check("rst_rdn",   io.rdn,   1);
    check("rst_wrn",   io.wrn,   1);
    check("rst_busy",  io.busy,  0);
    check("rst_err",   io.err,   0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("preload_sel_x", io.sel_x, 8'hFF);

    foreach (vecs[i]) begin
      if (vecs[i].do_load) begin
        do_load(vecs[i].load_val);
        check("load_sel_x", io.sel_x, vecs[i].ld_x);
        check("load_sel_y", io.sel_y, vecs[i].ld_y);
        check("load_err",   io.err,   0);
        check("load_busy",  io.busy,  0);
        check("load_strb",  {io.rdn, io.wrn}, 2'b11);
      end
      e.is_read = vecs[i].is_read;
      e.strobe  = vecs[i].exp_strobe;
      e.err     = vecs[i].exp_err;
      e.sel_x   = vecs[i].exp_x;
      e.sel_y   = vecs[i].exp_y;
      exp_q.push_back(e);
      do_xfer(vecs[i].is_read, vecs[i].rdy_delay);
    end

    // load and write request in the same cycle: load only
    @(negedge clk);
    io.bus = 8'h12; io.loadn = 1'b0; io.to_devn = 1'b0;
    @(negedge clk);
    io.loadn = 1'b1; io.to_devn = 1'b1;
    check("ldpri_busy",  io.busy,  0);
    check("ldpri_wrn",   io.wrn,   1);
    check("ldpri_sel_x", io.sel_x, 8'hFB);
    check("ldpri_sel_y", io.sel_y, 8'hFB);
    @(negedge clk);
    check("ldpri_busy2", io.busy,  0);

    // both directions requested: error, no transfer
    @(negedge clk);
    io.from_devn = 1'b0; io.to_devn = 1'b0;
    @(negedge clk);
    io.from_devn = 1'b1; io.to_devn = 1'b1;
    check("both_err",  io.err,  1);
    check("both_busy", io.busy, 0);
    check("both_strb", {io.rdn, io.wrn}, 2'b11);
    @(negedge clk);
    check("both_busy2", io.busy, 0);

    // back-to-back reads with the request held low
    do_load(8'h00);
    check("b2b_load_err", io.err, 0);
    e = '{1'b1, 1, 1'b0, 8'hFD, 8'hFE};
    exp_q.push_back(e);
    e = '{1'b1, 1, 1'b0, 8'hFB, 8'hFE};
    exp_q.push_back(e);
    @(negedge clk);
    io.dev_rdy = 1'b1; io.from_devn = 1'b0;
    wait_busy(1'b1, "b2b_rise1");
    wait_busy(1'b0, "b2b_fall1");
    gap = 1;
    ok  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (io.busy) begin
        ok = 1;
        break;
      end
      gap++;
    end
    io.from_devn = 1'b1;
    check("b2b_restart", ok, 1);
    check("b2b_gap", gap, 1);
    wait_busy(1'b0, "b2b_fall2");
    io.dev_rdy = 1'b0;

    // reset pulsed while the read strobe is active
    @(negedge clk);
    io.from_devn = 1'b0;
    @(negedge clk);
    io.from_devn = 1'b1;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!io.rdn) begin
        ok = 1;
        break;
      end
    end
    check("mid_strobe_seen", ok, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_rdn",   io.rdn,   1);
    check("mid_rst_wrn",   io.wrn,   1);
    check("mid_rst_busy",  io.busy,  0);
    check("mid_rst_err",   io.err,   0);
    check("mid_rst_sel_x", io.sel_x, 8'hFF);
    check("mid_rst_sel_y", io.sel_y, 8'hFF);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_busy", io.busy, 0);
    check("post_rst_rdn",  io.rdn,  1);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
